// File: rtl/front_panel_loader.sv
// Front-panel input controller: debounces pushbuttons, assembles a 16-bit value from
// hex digits on the switches, and writes it to a selected register over a req/ack port.
module front_panel_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_n,
  input  logic [9:0]  sw,
  input  logic        wr_ack,
  output logic        wr_en,
  output logic [2:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        step_pulse,
  output logic [15:0] entry_value,
  output logic [2:0]  digit_count,
  output logic        busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [0:0] {
    ST_ENTRY = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  // Key conditioning state: all keys idle high (released) out of reset.
  logic [3:0]         sync1_q, sync1_d;
  logic [3:0]         sync2_q, sync2_d;
  logic [3:0]         level_q, level_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [3:0]         press_q, press_d;

  state_t      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  dcnt_q, dcnt_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic ev_digit, ev_commit, ev_clear;
  logic sw_unused;

  assign sw_unused = ^sw[9:7];

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      // A full count means the new level held long enough: flip it this edge.
      if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
        press_d[i] = level_q[i];
      end else if (sync2_q[i] != level_q[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'b1111;
      sync2_q <= 4'b1111;
      level_q <= 4'b1111;
      cnt_q   <= '0;
      press_q <= 4'b0000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign ev_digit  = press_q[0];
  assign ev_commit = press_q[1];
  assign ev_clear  = press_q[2];

  // Write port: wr_en is the request; wr_addr/wr_data are held stable while it is
  // high; the transfer completes on the first rising edge with wr_en and wr_ack both 1.
  always_comb begin
    state_d   = state_q;
    entry_d   = entry_q;
    dcnt_d    = dcnt_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_ENTRY: begin
        if (ev_clear) begin
          entry_d = 16'h0000;
          dcnt_d  = 3'd0;
        end else if (ev_commit) begin
          if (dcnt_q != 3'd0) begin
            wr_addr_d = sw[6:4];
            wr_data_d = entry_q;
            wr_en_d   = 1'b1;
            state_d   = ST_WRITE;
          end
        end else if (ev_digit) begin
          entry_d = {entry_q[11:0], sw[3:0]};
          if (dcnt_q != 3'd4) begin
            dcnt_d = dcnt_q + 3'd1;
          end
        end
      end
      ST_WRITE: begin
        // Key events other than step are dropped while the write is outstanding.
        if (wr_ack) begin
          wr_en_d = 1'b0;
          entry_d = 16'h0000;
          dcnt_d  = 3'd0;
          state_d = ST_ENTRY;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ENTRY;
      entry_q   <= 16'h0000;
      dcnt_q    <= 3'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 3'd0;
      wr_data_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      dcnt_q    <= dcnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign step_pulse  = press_q[3];
  assign entry_value = entry_q;
  assign digit_count = dcnt_q;
  assign busy        = (state_q == ST_WRITE);

endmodule

// File: tb/tb_front_panel_loader.sv
// Directed bench for front_panel_loader: digit entry, commit handshake, debounce
// timing, event priority, step pulse and asynchronous reset.
module tb_front_panel_loader;

  localparam int DEB = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  key_n;
  logic [9:0]  sw;
  logic        wr_ack;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        step_pulse;
  logic [15:0] entry_value;
  logic [2:0]  digit_count;
  logic        busy;

  int n_checks;
  int n_fail;

  front_panel_loader #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk),
    .rst(rst),
    .key_n(key_n),
    .sw(sw),
    .wr_ack(wr_ack),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .step_pulse(step_pulse),
    .entry_value(entry_value),
    .digit_count(digit_count),
    .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: every step lands 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold key k low until its press pulse is visible (cycle starting at edge DEB+3).
  task automatic key_press(input int k);
    key_n[k] = 1'b0;
    repeat (DEB + 3) tick();
    key_n[k] = 1'b1;
  endtask

  task automatic settle();
    repeat (DEB + 5) tick();
  endtask

  task automatic press(input int k);
    key_press(k);
    tick();
    settle();
  endtask

  task automatic enter_digit(input logic [3:0] d);
    sw[3:0] = d;
    press(0);
  endtask

  int pulses;
  logic busy_at_pulse;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    key_n    = 4'hF;
    sw       = 10'h000;
    wr_ack   = 1'b0;
    repeat (3) tick();

    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_entry", 32'(entry_value), 32'd0);
    check("rst_dcnt", 32'(digit_count), 32'd0);
    check("rst_step", 32'(step_pulse), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // Digit entry and saturation
    enter_digit(4'h1);
    check("d1_entry", 32'(entry_value), 32'h0001);
    check("d1_dcnt", 32'(digit_count), 32'd1);
    enter_digit(4'h2);
    enter_digit(4'h3);
    check("d3_dcnt", 32'(digit_count), 32'd3);
    enter_digit(4'h4);
    check("d4_entry", 32'(entry_value), 32'h1234);
    check("d4_dcnt", 32'(digit_count), 32'd4);
    enter_digit(4'h5);
    check("d5_entry", 32'(entry_value), 32'h2345);
    check("d5_dcnt", 32'(digit_count), 32'd4);

    press(2);
    check("clr_entry", 32'(entry_value), 32'd0);
    check("clr_dcnt", 32'(digit_count), 32'd0);

    // Commit handshake
    enter_digit(4'h1);
    enter_digit(4'h2);
    enter_digit(4'h3);
    enter_digit(4'h4);
    sw = {3'b000, 3'd5, 4'h0};
    key_press(1);
    check("pre_commit_wr_en", 32'(wr_en), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("hold_wr_en", 32'(wr_en), 32'd1);
      check("hold_addr", 32'(wr_addr), 32'd5);
      check("hold_data", 32'(wr_data), 32'h1234);
      tick();
    end
    check("hold_busy", 32'(busy), 32'd1);
    settle();
    sw = {3'b000, 3'd2, 4'h9};
    press(0);
    check("wr_digit_data", 32'(wr_data), 32'h1234);
    check("wr_digit_addr", 32'(wr_addr), 32'd5);
    check("wr_digit_entry", 32'(entry_value), 32'h1234);
    check("wr_digit_dcnt", 32'(digit_count), 32'd4);
    check("wr_digit_wr_en", 32'(wr_en), 32'd1);
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    check("ack_wr_en", 32'(wr_en), 32'd0);
    check("ack_busy", 32'(busy), 32'd0);
    check("ack_entry", 32'(entry_value), 32'd0);
    check("ack_dcnt", 32'(digit_count), 32'd0);

    // One-cycle write with wr_ack already high
    wr_ack = 1'b1;
    enter_digit(4'hA);
    check("ack_idle_wr_en", 32'(wr_en), 32'd0);
    check("ack_idle_entry", 32'(entry_value), 32'h000A);
    sw = {3'b000, 3'd3, 4'h0};
    key_press(1);
    tick();
    check("w1_wr_en", 32'(wr_en), 32'd1);
    check("w1_addr", 32'(wr_addr), 32'd3);
    check("w1_data", 32'(wr_data), 32'h000A);
    tick();
    check("w1_done_wr_en", 32'(wr_en), 32'd0);
    check("w1_done_busy", 32'(busy), 32'd0);
    check("w1_done_dcnt", 32'(digit_count), 32'd0);
    wr_ack = 1'b0;
    settle();

    // Debounce: 5-cycle toggles are rejected, then a steady press lands at edge 19
    sw = {3'b000, 3'd0, 4'h7};
    for (int s = 0; s < 8; s++) begin
      key_n[0] = (s % 2 == 0) ? 1'b0 : 1'b1;
      repeat (5) tick();
    end
    check("bounce_entry", 32'(entry_value), 32'd0);
    check("bounce_dcnt", 32'(digit_count), 32'd0);
    key_n[0] = 1'b0;
    repeat (DEB + 3) tick();
    check("lat_edge19_entry", 32'(entry_value), 32'd0);
    tick();
    check("lat_edge20_entry", 32'(entry_value), 32'h0007);
    check("lat_edge20_dcnt", 32'(digit_count), 32'd1);
    repeat (40) tick();
    check("held_dcnt", 32'(digit_count), 32'd1);
    key_n[0] = 1'b1;
    settle();
    check("release_dcnt", 32'(digit_count), 32'd1);

    // Priority: clear and commit in the same cycle
    key_n[1] = 1'b0;
    key_n[2] = 1'b0;
    repeat (DEB + 3) tick();
    key_n[1] = 1'b1;
    key_n[2] = 1'b1;
    tick();
    check("prio_entry", 32'(entry_value), 32'd0);
    check("prio_dcnt", 32'(digit_count), 32'd0);
    check("prio_wr_en", 32'(wr_en), 32'd0);
    check("prio_busy", 32'(busy), 32'd0);
    settle();

    // Empty commit
    press(1);
    check("empty_wr_en", 32'(wr_en), 32'd0);
    check("empty_busy", 32'(busy), 32'd0);

    // Step pulse timing: high only in the cycle starting at edge 19
    key_n[3] = 1'b0;
    for (int i = 1; i <= 21; i++) begin
      tick();
      check($sformatf("step_e%0d", i), 32'(step_pulse), (i == DEB + 3) ? 32'd1 : 32'd0);
    end
    key_n[3] = 1'b1;
    pulses = 0;
    repeat (DEB + 8) begin
      tick();
      if (step_pulse) pulses++;
    end
    check("step_release_pulses", 32'(pulses), 32'd0);

    // Step while busy
    enter_digit(4'hC);
    sw = {3'b000, 3'd2, 4'h0};
    key_press(1);
    tick();
    check("sb_busy", 32'(busy), 32'd1);
    pulses = 0;
    busy_at_pulse = 1'b0;
    key_n[3] = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (step_pulse) begin
        pulses++;
        busy_at_pulse = busy;
      end
      if (i == 20) key_n[3] = 1'b1;
    end
    check("sb_pulses", 32'(pulses), 32'd1);
    check("sb_busy_at_pulse", 32'(busy_at_pulse), 32'd1);
    check("sb_wr_data", 32'(wr_data), 32'h000C);

    // Asynchronous reset mid-write
    check("pre_rst_wr_en", 32'(wr_en), 32'd1);
    check("pre_rst_entry", 32'(entry_value), 32'h000C);
    rst = 1'b1;
    #1;
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_entry", 32'(entry_value), 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    enter_digit(4'h6);
    check("post_rst_entry", 32'(entry_value), 32'h0006);
    check("post_rst_dcnt", 32'(digit_count), 32'd1);
    check("post_rst_wr_en", 32'(wr_en), 32'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
